// File: rtl/cdt_pkg.sv
// Shared definitions for the CDT run-level sequencing logic: state codes and default limits.
package cdt_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StClr     = 3'd1,
        StWaitLow = 3'd2,
        StArm     = 3'd3,
        StOn      = 3'd4,
        StDrain   = 3'd5
    } state_t;

    localparam int unsigned DEF_CLR_CYCLES = 16;
    localparam int unsigned DEF_MAX_SPILL  = 500000000;
    localparam int unsigned DEF_RO_TIMEOUT = 125000000;
    localparam int unsigned DEF_CNT_W      = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter. Clear with enable loads 1 so a count can restart on the same edge.
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count;
        if (clr) begin
            count_d = en ? CNT_W'(1) : '0;
        end else if (en && (count != '1)) begin
            count_d = count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_d;
        end
    end

endmodule

// File: rtl/spill_sequencer.sv
// Run-level sequencer: resets the live cleaner, gates trigger enable over a spill and
// handshakes the end-of-spill readout with the DAQ.
module spill_sequencer
    import cdt_pkg::*;
#(
    parameter int unsigned CLR_CYCLES = DEF_CLR_CYCLES,
    parameter int unsigned MAX_SPILL  = DEF_MAX_SPILL,
    parameter int unsigned RO_TIMEOUT = DEF_RO_TIMEOUT,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_en,
    input  logic             live_clean,
    input  logic             ro_ack,
    output logic             cleaner_rst,
    output logic             trig_en,
    output logic             spill_start,
    output logic             spill_end,
    output logic             ro_req,
    output logic [15:0]      spill_cnt,
    output logic [CNT_W-1:0] spill_len,
    output logic             err_long,
    output logic             err_ro,
    output logic [2:0]       state
);

    localparam logic [CNT_W-1:0] ClrLast = CNT_W'(CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0] MaxLen  = CNT_W'(MAX_SPILL);
    localparam logic [CNT_W-1:0] RoLimit = CNT_W'(RO_TIMEOUT);

    state_t           state_q;
    logic             live_q;
    logic             clr_clr, clr_en, len_clr, len_en, to_clr, to_en;
    logic [CNT_W-1:0] clr_count, len_count, to_count;
    logic             live_rise, on_exit, drain_exit;

    assign live_rise  = live_clean & ~live_q;
    // Live falling takes priority over the length limit so a coincident fall is a normal end.
    assign on_exit    = ~live_clean | (len_count >= MaxLen);
    assign drain_exit = ro_ack | (to_count >= RoLimit);
    assign state      = state_q;

    always_comb begin
        clr_clr = 1'b0;
        clr_en  = 1'b0;
        len_clr = 1'b0;
        len_en  = 1'b0;
        to_clr  = 1'b0;
        to_en   = 1'b0;
        unique case (state_q)
            StIdle:  clr_clr = 1'b1;
            StClr:   clr_en  = 1'b1;
            StArm: begin
                len_clr = 1'b1;
                len_en  = live_rise;
            end
            StOn: begin
                len_en = 1'b1;
                // Holding the timeout counter at 1 makes DRAIN entry start counting from 1.
                to_clr = 1'b1;
                to_en  = 1'b1;
            end
            StDrain: to_en = 1'b1;
            default: ;
        endcase
    end

    sat_counter #(.CNT_W(CNT_W)) u_clr_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_clr),
        .en    (clr_en),
        .count (clr_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_len_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (len_clr),
        .en    (len_en),
        .count (len_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_to_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (to_clr),
        .en    (to_en),
        .count (to_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            live_q      <= 1'b0;
            cleaner_rst <= 1'b0;
            trig_en     <= 1'b0;
            spill_start <= 1'b0;
            spill_end   <= 1'b0;
            ro_req      <= 1'b0;
            spill_cnt   <= '0;
            spill_len   <= '0;
            err_long    <= 1'b0;
            err_ro      <= 1'b0;
        end else begin
            live_q      <= live_clean;
            spill_start <= 1'b0;
            spill_end   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (run_en) begin
                        state_q     <= StClr;
                        cleaner_rst <= 1'b1;
                        spill_cnt   <= '0;
                        err_long    <= 1'b0;
                        err_ro      <= 1'b0;
                    end
                end
                StClr: begin
                    if (clr_count == ClrLast) begin
                        cleaner_rst <= 1'b0;
                        state_q     <= run_en ? StWaitLow : StIdle;
                    end
                end
                StWaitLow: begin
                    if (!live_clean) begin
                        state_q <= StArm;
                    end
                end
                StArm: begin
                    if (live_rise) begin
                        state_q     <= StOn;
                        spill_start <= 1'b1;
                        trig_en     <= 1'b1;
                    end
                end
                StOn: begin
                    if (on_exit) begin
                        state_q   <= StDrain;
                        trig_en   <= 1'b0;
                        spill_end <= 1'b1;
                        spill_len <= len_count;
                        ro_req    <= 1'b1;
                        if (spill_cnt != 16'hFFFF) begin
                            spill_cnt <= spill_cnt + 16'd1;
                        end
                        if (live_clean) begin
                            err_long <= 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (drain_exit) begin
                        ro_req  <= 1'b0;
                        state_q <= run_en ? StWaitLow : StIdle;
                        if (!ro_ack) begin
                            err_ro <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    cleaner_rst <= 1'b0;
                    trig_en     <= 1'b0;
                    ro_req      <= 1'b0;
                end
            endcase
        end
    end

endmodule
